// File: rtl/seq_det_sched_pkg.sv
// seq_det_pkg: shared constants and types for the sequence-detector scheduler.
//   - FSM state encoding (IDLE, CLR, SHIFT, DRAIN, RESP)
//   - default frame width / detector latency and the latency ceiling
//   - requester id constants
package seq_det_pkg;

  localparam int W_DEF       = 8;
  localparam int DET_LAT_DEF = 1;
  localparam int DET_LAT_MAX = 3;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_CLR   = S_CLR,
    ST_SHIFT = S_SHIFT,
    ST_DRAIN = S_DRAIN,
    ST_RESP  = S_RESP
  } state_t;

endpackage

// File: rtl/seq_det_sched_if.sv
// seq_det_sched_if: requester handshakes and response bus of the scheduler.
//   master: requester side (drives valid/data, sees ready and the response)
//   slave : scheduler side
interface seq_det_sched_if #(parameter int W = 8);
  localparam int CW = $clog2(W + 1);

  logic          req0_valid;
  logic [W-1:0]  req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [W-1:0]  req1_data;
  logic          req1_ready;
  logic          rsp_valid;
  logic          rsp_id;
  logic [CW-1:0] rsp_count;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
  );
endinterface

// File: rtl/seq_det_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_valid[1:0] : request lines
//   i_accept     : the current grant was taken; advance the pointer
//   o_grant[1:0] : one-hot grant (combinational)
module rr_arb2
  import seq_det_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // id of the requester granted most recently; a tie goes to the other one
  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last == ID_REQ1) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Reset as if requester 1 went last so requester 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_last <= ID_REQ1;
    else if (i_accept) r_last <= o_grant[1];
  end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: arbitrates W-bit frames from two requesters, serializes the
// granted frame MSB-first onto the detector input, clears the detector first,
// counts detector hits over a latency-shifted window and reports the count
// tagged with the requester id.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : requester handshakes + response strobe (slave side)
//   o_det_in     : serial bit to the detector
//   o_det_clr    : detector clear (high during reset and in CLR)
//   i_det_out    : detector match pulse
//   o_busy       : high whenever the FSM is not in IDLE
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DET_LAT = DET_LAT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seq_det_sched_if.slave   bus,
  output logic             o_det_in,
  output logic             o_det_clr,
  input  logic             i_det_out,
  output logic             o_busy
);

  localparam int CW  = $clog2(W + 1);
  // one counter spans SHIFT and DRAIN, so it must reach W+DET_LAT-1
  localparam int CYW = $clog2(W + DET_LAT_MAX + 1);
  localparam logic [CYW-1:0] LAST_SHIFT = CYW'(W - 1);
  localparam logic [CYW-1:0] LAST_WIN   = CYW'(W + DET_LAT - 1);

  state_t         r_state;
  logic [W-1:0]   r_sr;
  logic [CYW-1:0] r_cyc;
  logic [CW-1:0]  r_cnt;
  logic           r_id;
  logic           r_rsp_valid;
  logic           r_det_in;
  logic           r_det_clr;
  logic           r_busy;

  logic [1:0] w_valid;
  logic [1:0] w_grant;
  logic [1:0] w_ready;
  logic       w_accept;
  logic       w_win;

  assign w_valid  = {bus.req1_valid, bus.req0_valid};
  assign w_ready  = (r_state == ST_IDLE) ? w_grant : 2'b00;
  assign w_accept = |(w_ready & w_valid);

  // The window trails the serialized bits by DET_LAT cycles and ends with
  // the last DRAIN cycle.
  assign w_win = ((r_state == ST_SHIFT) || (r_state == ST_DRAIN)) &&
                 (int'(r_cyc) >= DET_LAT);

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (w_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Outputs are registered one cycle ahead of the state they belong to:
  // det_in for SHIFT cycle k is loaded on the edge entering that cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cyc       <= '0;
      r_cnt       <= '0;
      r_id        <= ID_REQ0;
      r_rsp_valid <= 1'b0;
      r_det_in    <= 1'b0;
      r_det_clr   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_det_clr   <= 1'b0;
      r_det_in    <= 1'b0;
      if (w_win && i_det_out) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_CLR;
            r_sr      <= w_grant[1] ? bus.req1_data : bus.req0_data;
            r_id      <= w_grant[1];
            r_det_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state  <= ST_SHIFT;
          r_cyc    <= '0;
          r_cnt    <= '0;
          r_det_in <= r_sr[W-1];
          r_sr     <= {r_sr[W-2:0], 1'b0};
        end
        ST_SHIFT: begin
          r_cyc <= r_cyc + 1'b1;
          r_sr  <= {r_sr[W-2:0], 1'b0};
          if (r_cyc == LAST_SHIFT) begin
            if (DET_LAT == 0) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_det_in <= r_sr[W-1];
          end
        end
        ST_DRAIN: begin
          r_cyc <= r_cyc + 1'b1;
          if (r_cyc == LAST_WIN) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_count  = r_cnt;
  assign o_det_in       = r_det_in;
  assign o_det_clr      = r_det_clr;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed bench for seq_det_sched (W=8, DET_LAT=1).
// A frame runner drives stimulus and records per-cycle observations relative
// to the accept cycle t; each test task compares them to hand-derived values.
module tb_seq_det_sched;
  import seq_det_pkg::*;

  localparam int W       = 8;
  localparam int DET_LAT = 1;
  localparam int CW      = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic det_in, det_clr, busy;
  logic det_out = 1'b0;

  seq_det_sched_if #(.W(W)) bus ();

  seq_det_sched #(.W(W), .DET_LAT(DET_LAT)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus.slave),
    .o_det_in  (det_in),
    .o_det_clr (det_clr),
    .i_det_out (det_out),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus knobs for run_frame
  logic pat [0:31];
  int   rst_at;
  int   raise0_at;
  bit   hold;

  // observations of the last run_frame (index k = cycle t+k)
  logic          rdy0_t, rdy1_t;
  logic          rec_in   [0:31];
  logic          rec_clr  [0:31];
  logic          rec_busy [0:31];
  logic          rec_rdy  [0:31];
  int            rsp_cyc;
  int            rsp_n;
  logic          rsp_id_o;
  logic [CW-1:0] rsp_cnt_o;

  task automatic clear_stim();
    for (int i = 0; i < 32; i++) pat[i] = 1'b0;
    rst_at    = -1;
    raise0_at = -1;
    hold      = 1'b0;
  endtask

  // Called #1 after a posedge with valids already set for cycle t.
  task automatic run_frame(input int ncyc);
    #1;
    rdy0_t    = bus.req0_ready;
    rdy1_t    = bus.req1_ready;
    det_out   = pat[0];
    rsp_cyc   = -1;
    rsp_n     = 0;
    rsp_id_o  = 1'b0;
    rsp_cnt_o = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 1 && !hold) begin
        if (rdy0_t) bus.req0_valid = 1'b0;
        if (rdy1_t) bus.req1_valid = 1'b0;
      end
      rec_in[k]   = det_in;
      rec_clr[k]  = det_clr;
      rec_busy[k] = busy;
      rec_rdy[k]  = bus.req0_ready | bus.req1_ready;
      if (bus.rsp_valid === 1'b1) begin
        rsp_n++;
        if (rsp_cyc < 0) begin
          rsp_cyc   = k;
          rsp_id_o  = bus.rsp_id;
          rsp_cnt_o = bus.rsp_count;
        end
      end
      det_out = pat[k];
      if (k == raise0_at) bus.req0_valid = 1'b1;
      if (k == rst_at) rst = 1'b1;
      if (rst_at >= 0 && k == rst_at + 2) rst = 1'b0;
    end
    det_out = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (det_clr !== 1'b1) begin errors++; $display("FAIL reset_det_clr: got %b want 1", det_clr); end
    checks++; if (det_in !== 1'b0) begin errors++; $display("FAIL reset_det_in: got %b want 0", det_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_count !== '0) begin errors++; $display("FAIL reset_rsp_count: got %0d want 0", bus.rsp_count); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (det_clr !== 1'b0) begin errors++; $display("FAIL reset_release_clr: got %b want 0", det_clr); end
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
  endtask

  task automatic test_single_frame();
    clear_stim();
    pat[5] = 1'b1;  // window cycle 2 (window opens at t+3)
    pat[8] = 1'b1;  // window cycle 5
    bus.req0_data  = 8'hA5;
    bus.req0_valid = 1'b1;
    run_frame(12);
    checks++; if ({rdy1_t, rdy0_t} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", {rdy1_t, rdy0_t}); end
    checks++; if (rsp_cyc != 11) begin errors++; $display("FAIL single_rsp_cycle: got %0d want 11", rsp_cyc); end
    checks++; if (rsp_n != 1) begin errors++; $display("FAIL single_rsp_pulses: got %0d want 1", rsp_n); end
    checks++; if (rsp_id_o !== ID_REQ0) begin errors++; $display("FAIL single_rsp_id: got %b want 0", rsp_id_o); end
    checks++; if (rsp_cnt_o !== 4'd2) begin errors++; $display("FAIL single_rsp_count: got %0d want 2", rsp_cnt_o); end
    checks++; if (rec_busy[11] !== 1'b1) begin errors++; $display("FAIL single_busy_resp: got %b want 1", rec_busy[11]); end
    checks++; if (rec_busy[12] !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", rec_busy[12]); end
  endtask

  task automatic test_bit_order();
    logic [7:0]  obs;
    logic [11:0] clr_v;
    clear_stim();
    bus.req1_data  = 8'b1011_0010;
    bus.req1_valid = 1'b1;
    run_frame(12);
    for (int k = 2; k <= 9; k++) obs[9-k] = rec_in[k];
    for (int k = 1; k <= 12; k++) clr_v[k-1] = rec_clr[k];
    checks++; if ({rdy1_t, rdy0_t} !== 2'b10) begin errors++; $display("FAIL bits_ready: got %b want 10", {rdy1_t, rdy0_t}); end
    checks++; if (obs !== 8'b1011_0010) begin errors++; $display("FAIL bits_serial: got %b want 10110010", obs); end
    checks++; if (rec_in[1] !== 1'b0) begin errors++; $display("FAIL bits_clr_in: got %b want 0", rec_in[1]); end
    checks++; if (rec_in[10] !== 1'b0) begin errors++; $display("FAIL bits_drain_in: got %b want 0", rec_in[10]); end
    checks++; if (clr_v !== 12'b0000_0000_0001) begin errors++; $display("FAIL bits_det_clr: got %b want 000000000001", clr_v); end
    checks++; if (rsp_id_o !== ID_REQ1) begin errors++; $display("FAIL bits_rsp_id: got %b want 1", rsp_id_o); end
    checks++; if (rsp_cnt_o !== 4'd0) begin errors++; $display("FAIL bits_rsp_count: got %0d want 0", rsp_cnt_o); end
  endtask

  task automatic test_window();
    clear_stim();
    for (int i = 0; i < 32; i++) pat[i] = 1'b1;
    bus.req0_valid = 1'b1;
    run_frame(12);
    checks++; if (rsp_cyc != 11) begin errors++; $display("FAIL window_rsp_cycle: got %0d want 11", rsp_cyc); end
    checks++; if (rsp_cnt_o !== 4'd8) begin errors++; $display("FAIL window_count: got %0d want 8", rsp_cnt_o); end
  endtask

  task automatic test_arbitration();
    logic [3:0] grants, ids;
    do_reset();
    clear_stim();
    hold = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_frame(12);
      grants[f] = rdy1_t;
      ids[f]    = rsp_id_o;
      checks++; if ((rdy0_t ^ rdy1_t) !== 1'b1) begin errors++; $display("FAIL arb_onehot_f%0d: got %b want one-hot", f, {rdy1_t, rdy0_t}); end
      checks++; if (rec_rdy[11] !== 1'b0) begin errors++; $display("FAIL arb_ready_busy_f%0d: got %b want 0", f, rec_rdy[11]); end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++; if (grants !== 4'b1010) begin errors++; $display("FAIL arb_grant_seq: got %b want 1010 (f3..f0)", grants); end
    checks++; if (ids !== 4'b1010) begin errors++; $display("FAIL arb_rsp_ids: got %b want 1010 (f3..f0)", ids); end
  endtask

  task automatic test_late_request();
    clear_stim();
    hold      = 1'b1;
    raise0_at = 4;
    bus.req1_valid = 1'b1;
    run_frame(12);
    checks++; if ({rdy1_t, rdy0_t} !== 2'b10) begin errors++; $display("FAIL late_first: got %b want 10", {rdy1_t, rdy0_t}); end
    checks++; if (rec_rdy[5] !== 1'b0) begin errors++; $display("FAIL late_ready_midframe: got %b want 0", rec_rdy[5]); end
    raise0_at = -1;
    run_frame(12);
    checks++; if ({rdy1_t, rdy0_t} !== 2'b01) begin errors++; $display("FAIL late_second: got %b want 01", {rdy1_t, rdy0_t}); end
    run_frame(12);
    checks++; if ({rdy1_t, rdy0_t} !== 2'b10) begin errors++; $display("FAIL late_third: got %b want 10", {rdy1_t, rdy0_t}); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    clear_stim();
    rst_at = 6;  // SHIFT bit 4
    bus.req0_valid = 1'b1;
    run_frame(14);
    checks++; if (rsp_n != 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d want 0", rsp_n); end
    checks++; if (rec_clr[7] !== 1'b1) begin errors++; $display("FAIL midrst_det_clr: got %b want 1", rec_clr[7]); end
    checks++; if (rec_busy[7] !== 1'b0) begin errors++; $display("FAIL midrst_busy_in_rst: got %b want 0", rec_busy[7]); end
    checks++; if (rec_busy[14] !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b want 0", rec_busy[14]); end
    checks++; if (rec_clr[14] !== 1'b0) begin errors++; $display("FAIL midrst_clr_after: got %b want 0", rec_clr[14]); end
    clear_stim();
    pat[4] = 1'b1;
    bus.req0_data  = 8'h3C;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    run_frame(12);
    bus.req1_valid = 1'b0;
    checks++; if ({rdy1_t, rdy0_t} !== 2'b01) begin errors++; $display("FAIL midrst_pair_grant: got %b want 01", {rdy1_t, rdy0_t}); end
    checks++; if (rsp_cyc != 11) begin errors++; $display("FAIL midrst_pair_cycle: got %0d want 11", rsp_cyc); end
    checks++; if (rsp_id_o !== ID_REQ0) begin errors++; $display("FAIL midrst_pair_id: got %b want 0", rsp_id_o); end
    checks++; if (rsp_cnt_o !== 4'd1) begin errors++; $display("FAIL midrst_pair_count: got %0d want 1", rsp_cnt_o); end
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    clear_stim();
    test_reset();
    test_single_frame();
    test_bit_order();
    test_window();
    test_arbitration();
    test_late_request();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
